// File: rtl/instr_loader.sv
// instr_loader: streams 32-bit instruction words into imem from address 0,
// then pulses St and waits for done. Optional HALT padding: LOADER_PAD_HALT_EN.
`timescale 1ns/1ps
`ifndef INSTR_BIT
`define INSTR_BIT 8
`endif

module instr_loader #(
    parameter int          ADDR_BIT  = `INSTR_BIT,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    input  logic                in_last,
    output logic                mem_we,
    output logic [ADDR_BIT-1:0] mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                St,
    input  logic                done,
    output logic                busy,
    output logic [ADDR_BIT:0]   word_cnt,
    output logic                overflow
);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, START, RUN} state_t;

    localparam logic [ADDR_BIT-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_BIT:0]   ONE       = 1;

    state_t              state;
    state_t              end_state;
    logic                accept;
    logic                at_end;
    logic [ADDR_BIT-1:0] wr_addr;

    assign accept  = in_valid & in_ready;
    // A new program always restarts at address 0.
    assign wr_addr = (state == IDLE) ? '0 : word_cnt[ADDR_BIT-1:0];
    assign at_end  = in_last | (wr_addr == LAST_ADDR);
    assign busy    = (state != IDLE);

`ifdef LOADER_PAD_HALT_EN
    assign end_state = (wr_addr == LAST_ADDR) ? START : CLEAR;
`else
    logic unused_halt;
    assign unused_halt = ^HALT_WORD;
    assign end_state   = START;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            St        <= 1'b0;
            word_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            St     <= 1'b0;
            unique case (state)
                IDLE, LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= in_data;
                        word_cnt  <= {1'b0, wr_addr} + ONE;
                        overflow  <= at_end & ~in_last;
                        if (at_end) begin
                            state    <= end_state;
                            in_ready <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
`ifdef LOADER_PAD_HALT_EN
                CLEAR: begin
                    // Continues from the last program write address.
                    mem_we    <= 1'b1;
                    mem_addr  <= mem_addr + 1'b1;
                    mem_wdata <= HALT_WORD;
                    if (mem_addr + 1'b1 == LAST_ADDR)
                        state <= START;
                end
`endif
                START: begin
                    St    <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (done) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
